// File: rtl/cache_dump_pkg.sv
// Shared types and constants for the cache dump buffer.
package cache_dump_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int DEFAULT_DEPTH = 128;
  localparam int DEFAULT_CNT_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    STALL,
    FLUSH,
    FINISH
  } state_e;

endpackage

// File: rtl/cache_dump_buf_word_fifo.sv
// Block-RAM word FIFO with a one-cycle read stage feeding a registered valid/ready output.
// level_o counts every word held, including the read stage and the output register.
module word_fifo
  import cache_dump_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  output logic          full_o,
  output logic [AW:0]   level_o,
  output logic [W-1:0]  out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_data_q;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;

  logic          pop;
  logic          s2_load;
  logic          rd_en;
  logic [AW:0]   mem_words;

  assign pop       = out_valid_q && out_ready_i;
  assign s2_load   = s1_valid_q && (!out_valid_q || out_ready_i);
  assign mem_words = level_q - (AW+1)'(s1_valid_q) - (AW+1)'(out_valid_q);
  // Prefetch whenever the read stage is empty or is handing its word on this cycle.
  assign rd_en     = (mem_words != '0) && (!s1_valid_q || s2_load);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q + (AW+1)'(push_i) - (AW+1)'(pop);
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = s1_data_q;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
    if (rd_en)  s1_data_q     <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign full_o      = (level_q == (AW+1)'(DEPTH));
  assign level_o     = level_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/cache_dump_buf.sv
// Sequential cache read-out into a word FIFO, drained over a valid/ready stream.
// Optional CACHE_DUMP_CHECKSUM_EN appends the two's complement of the word sum after the data.
module cache_dump_buf
  import cache_dump_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             cache_req,
  output logic [31:0]      cache_addr,
  input  logic             cache_ready,
  input  logic             cache_rvalid,
  input  logic [31:0]      cache_rdata,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] remain_q, remain_d;

  logic             push;
  logic [31:0]      push_data;
  logic             fifo_full;
  logic [AW:0]      fifo_level;
  logic [AW+1:0]    level_next;
  logic             room_after;
  logic             csum_pend;
  logic [31:0]      csum_word;

  // Occupancy after this cycle's push and pop; the single outstanding read always has a slot.
  assign level_next = {1'b0, fifo_level} + (AW+2)'(1) - (AW+2)'(out_valid && out_ready);
  assign room_after = level_next < (AW+2)'(DEPTH);

`ifdef CACHE_DUMP_CHECKSUM_EN
  localparam state_e ZERO_NEXT = FLUSH;
  logic [31:0] sum_q;
  logic        csum_pend_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_q       <= '0;
      csum_pend_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      sum_q       <= '0;
      csum_pend_q <= 1'b1;
    end else if (push && state_q == WAIT) begin
      sum_q       <= sum_q + cache_rdata;
    end else if (push && state_q == FLUSH) begin
      csum_pend_q <= 1'b0;
    end
  end

  assign csum_pend = csum_pend_q;
  assign csum_word = ~sum_q + 32'd1;
`else
  localparam state_e ZERO_NEXT = FINISH;
  assign csum_pend = 1'b0;
  assign csum_word = '0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    push      = 1'b0;
    push_data = cache_rdata;
    cache_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr & ~32'h3;
          remain_d = word_count;
          state_d  = (word_count == '0) ? ZERO_NEXT : ISSUE;
        end
      end
      ISSUE: begin
        cache_req = 1'b1;
        if (cache_ready) state_d = WAIT;
      end
      WAIT: begin
        if (cache_rvalid) begin
          push     = 1'b1;
          addr_d   = addr_q + 32'(WORD_BYTES);
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) state_d = FLUSH;
          else if (room_after)       state_d = ISSUE;
          else                       state_d = STALL;
        end
      end
      STALL: begin
        if (!fifo_full) state_d = ISSUE;
      end
      FLUSH: begin
        if (csum_pend) begin
          if (!fifo_full) begin
            push      = 1'b1;
            push_data = csum_word;
          end
        end else if (fifo_level == '0) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign cache_addr = addr_q;

  word_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .push_data_i (push_data),
    .full_o      (fifo_full),
    .level_o     (fifo_level),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

endmodule

// File: tb/tb_cache_dump_buf.sv
// Randomized scoreboard bench for cache_dump_buf; expected stream derived from address ranges.
module tb_cache_dump_buf;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [31:0] base_addr;
  logic [9:0]  word_count;
  logic        busy, done;
  logic        cache_req;
  logic [31:0] cache_addr;
  logic        cache_ready, cache_rvalid;
  logic [31:0] cache_rdata;
  logic [31:0] out_data;
  logic        out_valid, out_ready;

  cache_dump_buf dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
    .cache_req    (cache_req),
    .cache_addr   (cache_addr),
    .cache_ready  (cache_ready),
    .cache_rvalid (cache_rvalid),
    .cache_rdata  (cache_rdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  int          req_cnt = 0, rx_cnt = 0, done_cnt = 0;
  logic [31:0] exp_req_addr = 0;
  logic [31:0] dbase = 0;
  logic [31:0] salt = 0;
  int          data_mode = 0;
  bit          resp_en = 1, inject = 0;
  int          rdy_lo = 0, rdy_hi = 0, rv_lo = 1, rv_hi = 1;
  int          ordy_mode = 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Reference memory contents as seen by the cache.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (data_mode)
      0:       return a;
      1:       return (a * 32'h9E3779B1) ^ salt;
      default: return ((a - dbase) >> 2) + 32'd1;
    endcase
  endfunction

  // Cache model: one request at a time, programmable ready and rvalid delays.
  initial begin
    int          phase, r_cnt;
    logic [31:0] r_addr;
    phase = 0; r_cnt = 0; r_addr = 0;
    cache_ready = 1'b0; cache_rvalid = 1'b0; cache_rdata = '0;
    forever begin
      @(negedge clk);
      cache_ready  = 1'b0;
      cache_rvalid = 1'b0;
      if (!rstn || !resp_en) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (cache_req) begin
               r_addr = cache_addr;
               req_cnt++;
               chk("req_addr", cache_addr, exp_req_addr);
               exp_req_addr = exp_req_addr + 32'd4;
               r_cnt = $urandom_range(rdy_hi, rdy_lo);
               phase = 1;
               if (r_cnt == 0) begin
                 cache_ready = 1'b1;
                 r_cnt = $urandom_range(rv_hi, rv_lo);
                 phase = 2;
               end
             end
          1: begin
               chk("req_held", {31'd0, cache_req}, 32'd1);
               chk("addr_stable", cache_addr, r_addr);
               r_cnt--;
               if (r_cnt == 0) begin
                 cache_ready = 1'b1;
                 r_cnt = $urandom_range(rv_hi, rv_lo);
                 phase = 2;
               end
             end
          default: begin
               chk("no_second_req", {31'd0, cache_req}, 32'd0);
               r_cnt--;
               if (r_cnt == 0) begin
                 cache_rvalid = 1'b1;
                 cache_rdata  = mem_word(r_addr);
                 phase = 0;
               end
             end
        endcase
      end
      if (inject) begin
        cache_rvalid = 1'b1;
        cache_rdata  = 32'hDEADBEEF;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ordy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(99, 0) < 60);
      endcase
    end
  end

  // Monitor: samples just before each rising edge, pops the scoreboard on every transfer.
  initial begin
    logic        stalled;
    logic [31:0] held;
    stalled = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rstn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", out_data, held);
        end
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          rx_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got 0x%08h required no word at %0t", out_data, $time);
          end else begin
            chk("out_data", out_data, exp_q.pop_front());
          end
        end
        stalled = out_valid && !out_ready;
        held    = out_data;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [31:0] b, input int cnt);
    @(negedge clk);
    base_addr  = b;
    word_count = 10'(cnt);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic do_dump(input logic [31:0] b, input int cnt);
    logic [31:0] sum;
    sum          = '0;
    dbase        = b & ~32'h3;
    exp_req_addr = dbase;
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(mem_word(dbase + 32'(4 * i)));
      sum = sum + mem_word(dbase + 32'(4 * i));
    end
`ifdef CACHE_DUMP_CHECKSUM_EN
    exp_q.push_back(32'd0 - sum);
`endif
    pulse_start(b, cnt);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_done_seen"}, {31'd0, done_cnt != d0}, 32'd1);
    repeat (3) @(negedge clk);
    #3;
    chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({name, "_all_words"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_vals(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_req"}, {31'd0, cache_req}, 32'd0);
    chk({name, "_addr"}, cache_addr, 32'd0);
    chk({name, "_ovalid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_odata"}, out_data, 32'd0);
  endtask

  initial begin
    int r0, x0, d0, c, last, still;
    rstn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    #1;
    reset_vals("reset");
    @(negedge clk);
    rstn = 1'b1;

    // basic dump: data equals address
    data_mode = 0; rdy_lo = 0; rdy_hi = 0; rv_lo = 1; rv_hi = 1; ordy_mode = 1;
    r0 = req_cnt;
    do_dump(32'h100, 4);
    wait_done("basic", 200);
    chk("basic_reads", 32'(req_cnt - r0), 32'd4);

    // backpressure: reads stop once the FIFO holds DEPTH words
    data_mode = 1; salt = $urandom; ordy_mode = 0;
    r0 = req_cnt;
    do_dump(32'h2000, 200);
    last = -1; still = 0; c = 0;
    while (still < 40 && c < 3000) begin
      @(negedge clk);
      c++;
      if (req_cnt == last) still++;
      else begin still = 0; last = req_cnt; end
    end
    chk("bp_reads_stalled", 32'(req_cnt - r0), 32'd128);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    ordy_mode = 1;
    wait_done("bp", 4000);
    chk("bp_reads_total", 32'(req_cnt - r0), 32'd200);

    // slow cache: ready after 5 cycles, data 7 cycles after acceptance
    rdy_lo = 5; rdy_hi = 5; rv_lo = 7; rv_hi = 7;
    do_dump(32'h4444_0003, 3);
    wait_done("slow", 500);

    // zero count
    rdy_lo = 0; rdy_hi = 1; rv_lo = 1; rv_hi = 2;
    r0 = req_cnt;
    do_dump(32'h800, 0);
    wait_done("zero", 20);
    chk("zero_no_req", 32'(req_cnt - r0), 32'd0);

    // start while busy is ignored
    rv_lo = 3; rv_hi = 3;
    r0 = req_cnt; x0 = rx_cnt;
    do_dump(32'h500, 6);
    repeat (5) @(negedge clk);
    pulse_start(32'h9000, 2);
    wait_done("busystart", 500);
    chk("busystart_reads", 32'(req_cnt - r0), 32'd6);
    chk("busystart_words", 32'(rx_cnt - x0), 32'd6);

    // reset mid-dump, stale rvalid, then a fresh dump
    rdy_lo = 0; rdy_hi = 1; rv_lo = 1; rv_hi = 2;
    x0 = rx_cnt;
    do_dump(32'h300, 10);
    c = 0;
    while (rx_cnt - x0 < 3 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("rst_three_words", {31'd0, (rx_cnt - x0) >= 3}, 32'd1);
    @(negedge clk);
    resp_en = 1'b0;
    rstn    = 1'b0;
    #1;
    reset_vals("midrst");
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    chk("stale_busy", {31'd0, busy}, 32'd0);
    chk("stale_req", {31'd0, cache_req}, 32'd0);
    chk("stale_ovalid", {31'd0, out_valid}, 32'd0);
    chk("stale_done", 32'(done_cnt - d0), 32'd0);
    resp_en = 1'b1;
    do_dump(32'h400, 2);
    wait_done("postrst", 200);

    // words 1,2,3 (checksum build appends 0xFFFFFFFA)
    data_mode = 2; rv_lo = 1; rv_hi = 1; rdy_lo = 0; rdy_hi = 0;
    do_dump(32'h1000, 3);
    wait_done("small", 200);

    // randomized dumps, including address wrap and heavy output backpressure
    for (int i = 0; i < 6; i++) begin
      int          cnt;
      logic [31:0] b;
      data_mode = 1; salt = $urandom;
      b   = (i == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h3)) : $urandom;
      cnt = (i == 5) ? 150 : $urandom_range(40, 1);
      rdy_lo = 0; rdy_hi = $urandom_range(3, 0);
      rv_lo  = 1; rv_hi  = $urandom_range(3, 1);
      ordy_mode = 2;
      do_dump(b, cnt);
      wait_done("rand", cnt * 25 + 200);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
